// File: rtl/wb_sdram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sdram_pkg : shared types for the Wishbone-to-SDRAM bridge        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package wb_sdram_pkg;

  localparam logic [7:0] DEFAULT_BASE = 8'h38;

  // FIFO entries carry the widest address a 32-bit window below BASE allows
  localparam int MAX_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            mask;
  } wfifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_sdram_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sdram_bridge_if : Wishbone classic slave bus bundle              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface wb_sdram_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_sdram_wfifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sdram_wfifo : posted-write FIFO with full/empty flags            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_sdram_wfifo
  import wb_sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  wfifo_entry_t din_i,
  input  logic         pop_i,
  output wfifo_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  wfifo_entry_t   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/wb_sdram_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sdram_bridge : Wishbone slave with posted writes to SDRAM ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_sdram_bridge
  import wb_sdram_pkg::*;
#(
  parameter int         ADDR_W     = 23,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BASE       = DEFAULT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_sdram_bridge_if.slave  wbs,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [31:0]       ctrl_wdata,
  output logic [3:0]        ctrl_mask,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [31:0]       ctrl_rdata,
  input  logic              ctrl_out_valid,
  output logic              wr_pending
);

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              abort_q, abort_d;

  logic              sel;
  logic              req_ok;
  logic              wr_accept;
  logic              rd_accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  wfifo_entry_t      push_entry;
  wfifo_entry_t      head_entry;
  logic              unused_ok;

  // No acceptance in the ack cycle: the master may still hold stb there
  assign sel       = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:24] == BASE);
  assign req_ok    = sel & ~ack_q;
  assign wr_accept = req_ok & wbs.wbs_we_i & ~fifo_full;
  assign rd_accept = req_ok & ~wbs.wbs_we_i & fifo_empty & (state_q == IDLE);
  assign fifo_pop  = (state_q == WR_ISSUE) & ~ctrl_busy;

  assign push_entry = '{addr: MAX_ADDR_W'(wbs.wbs_adr_i[ADDR_W-1:0]),
                        data: wbs.wbs_dat_i,
                        mask: wbs.wbs_sel_i};

  wb_sdram_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_accept),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_pending    = ~fifo_empty;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign unused_ok     = ^{wbs.wbs_adr_i, head_entry.addr};

  always_comb begin
    state_d       = state_q;
    ack_d         = wr_accept;
    dat_d         = dat_q;
    rd_addr_d     = rd_addr_q;
    abort_d       = abort_q;
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = '0;
    ctrl_wdata    = '0;
    ctrl_mask     = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WR_ISSUE;
        end else if (rd_accept) begin
          state_d   = RD_ISSUE;
          rd_addr_d = wbs.wbs_adr_i[ADDR_W-1:0];
          abort_d   = 1'b0;
        end
      end
      WR_ISSUE: begin
        ctrl_in_valid = 1'b1;
        ctrl_rw       = 1'b1;
        ctrl_addr     = head_entry.addr[ADDR_W-1:0];
        ctrl_wdata    = head_entry.data;
        ctrl_mask     = head_entry.mask;
        if (!ctrl_busy) state_d = IDLE;
      end
      RD_ISSUE: begin
        ctrl_in_valid = 1'b1;
        ctrl_addr     = rd_addr_q;
        if (!wbs.wbs_cyc_i) abort_d = 1'b1;
        if (!ctrl_busy)     state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!wbs.wbs_cyc_i) abort_d = 1'b1;
        // An abandoned read still drains the controller but returns nothing
        if (ctrl_out_valid) begin
          state_d = IDLE;
          if (!abort_q && wbs.wbs_cyc_i) begin
            dat_d = ctrl_rdata;
            ack_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      rd_addr_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      rd_addr_q <= rd_addr_d;
      abort_q   <= abort_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_sdram_bridge : directed self-checking bench for the bridge    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_wb_sdram_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_mask;
  logic        ctrl_in_valid;
  logic        ctrl_busy = 1'b0;
  logic [31:0] ctrl_rdata = '0;
  logic        ctrl_out_valid = 1'b0;
  logic        wr_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } cmd_t;

  cmd_t log_q[$];

  always #5 clk = ~clk;

  wb_sdram_bridge_if bus();

  wb_sdram_bridge #(
    .ADDR_W     (23),
    .FIFO_DEPTH (4),
    .BASE       (8'h38)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wbs            (bus),
    .ctrl_addr      (ctrl_addr),
    .ctrl_rw        (ctrl_rw),
    .ctrl_wdata     (ctrl_wdata),
    .ctrl_mask      (ctrl_mask),
    .ctrl_in_valid  (ctrl_in_valid),
    .ctrl_busy      (ctrl_busy),
    .ctrl_rdata     (ctrl_rdata),
    .ctrl_out_valid (ctrl_out_valid),
    .wr_pending     (wr_pending)
  );

  // Record every command the controller accepts, in order
  always @(posedge clk) begin
    cmd_t c;
    if (rst_n && ctrl_in_valid && !ctrl_busy) begin
      c.rw   = ctrl_rw;
      c.addr = ctrl_addr;
      c.data = ctrl_wdata;
      c.mask = ctrl_mask;
      log_q.push_back(c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sl);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sl;
    bus.wbs_dat_i = dat;
    bus.wbs_adr_i = adr;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0;
    bus_idle();
    step();
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wb: ack=%b dat=%h expected ack=0 dat=0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    n_tests++;
    if ({ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_valid=%b rw=%b addr=%h wdata=%h mask=%h expected all 0",
               ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask);
    end
    n_tests++;
    if (wr_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pending: got %b expected 0", wr_pending);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ctrl_in_valid !== 1'b0 || bus.wbs_ack_o !== 1'b0 || wr_pending !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_quiet: activity seen after reset, expected none for 10 cycles");
    end
  endtask

  task automatic test_single_write();
    log_q.delete();
    ctrl_busy = 1'b0;
    bus_drive(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF);
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b1 || ctrl_in_valid !== 1'b0 || wr_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack: ack=%b in_valid=%b pending=%b expected 1 0 1",
               bus.wbs_ack_o, ctrl_in_valid, wr_pending);
    end
    bus_idle();
    step();
    n_tests++;
    if (ctrl_in_valid !== 1'b1 || ctrl_rw !== 1'b1 || ctrl_addr !== 23'h10 ||
        ctrl_wdata !== 32'hDEAD_BEEF || ctrl_mask !== 4'hF || bus.wbs_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_issue: iv=%b rw=%b addr=%h wd=%h mask=%h ack=%b expected 1 1 000010 deadbeef f 0",
               ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask, bus.wbs_ack_o);
    end
    step();
    n_tests++;
    if (ctrl_in_valid !== 1'b0 || wr_pending !== 1'b0 || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL wr_done: iv=%b pending=%b cmds=%0d expected 0 0 1",
               ctrl_in_valid, wr_pending, log_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sels [5];
    logic [22:0] ea;
    int          acks;
    int          waited;
    logic        got;
    sels = '{4'hF, 4'h1, 4'h3, 4'h0, 4'hC};
    log_q.delete();
    ctrl_busy = 1'b1;
    acks = 0;
    got  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_drive(1'b1, 32'h3800_0100 + 32'(4 * i), 32'h1111_0000 + 32'(i), sels[i]);
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (bus.wbs_ack_o === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (got) acks++;
    end
    n_tests++;
    if (acks != 4 || got !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_acks: acks=%0d fifth_acked=%b expected 4 and 0", acks, got);
    end
    n_tests++;
    if (ctrl_in_valid !== 1'b1 || ctrl_addr !== 23'h100 || ctrl_wdata !== 32'h1111_0000) begin
      n_fail++;
      $display("FAIL b2b_hold: iv=%b addr=%h wd=%h expected 1 000100 11110000",
               ctrl_in_valid, ctrl_addr, ctrl_wdata);
    end
    ctrl_busy = 1'b0;
    waited = 0;
    got = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bus.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        waited = c;
        break;
      end
    end
    n_tests++;
    if (!got || waited != 2) begin
      n_fail++;
      $display("FAIL b2b_fifth: acked=%b after %0d cycles expected acked after 2", got, waited);
    end
    bus_idle();
    repeat (20) step();
    n_tests++;
    if (log_q.size() != 5 || wr_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: cmds=%0d pending=%b expected 5 0", log_q.size(), wr_pending);
    end else begin
      for (int i = 0; i < 5; i++) begin
        ea = 23'h100 + 23'(4 * i);
        n_tests++;
        if (log_q[i].rw !== 1'b1 || log_q[i].addr !== ea ||
            log_q[i].data !== 32'h1111_0000 + 32'(i) || log_q[i].mask !== sels[i]) begin
          n_fail++;
          $display("FAIL b2b_cmd%0d: rw=%b addr=%h data=%h mask=%h expected 1 %h %h %h", i,
                   log_q[i].rw, log_q[i].addr, log_q[i].data, log_q[i].mask,
                   ea, 32'h1111_0000 + 32'(i), sels[i]);
        end
      end
    end
  endtask

  task automatic test_read_after_write();
    logic found;
    log_q.delete();
    ctrl_busy = 1'b0;
    bus_drive(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF);
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wack: ack=%b expected 1", bus.wbs_ack_o);
    end
    bus_drive(1'b0, 32'h3800_0010, 32'h0, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (ctrl_in_valid === 1'b1 && ctrl_rw === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_tests++;
    if (!found || log_q.size() != 1 || wr_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_order: read_seen=%b cmds_before=%0d pending=%b expected 1 1 0",
               found, log_q.size(), wr_pending);
    end
    n_tests++;
    if (ctrl_addr !== 23'h10 || ctrl_mask !== 4'h0) begin
      n_fail++;
      $display("FAIL raw_rdcmd: addr=%h mask=%h expected 000010 0", ctrl_addr, ctrl_mask);
    end
    step();
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0 || ctrl_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_wait: ack=%b iv=%b expected 0 0", bus.wbs_ack_o, ctrl_in_valid);
    end
    ctrl_rdata     = 32'hDEAD_BEEF;
    ctrl_out_valid = 1'b1;
    step();
    ctrl_out_valid = 1'b0;
    ctrl_rdata     = 32'h0;
    n_tests++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL raw_rack: ack=%b dat=%h expected 1 deadbeef", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    bus_idle();
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_onecycle: ack=%b expected 0", bus.wbs_ack_o);
    end
    ctrl_rdata     = 32'h1234_5678;
    ctrl_out_valid = 1'b1;
    step();
    ctrl_out_valid = 1'b0;
    step();
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL stray_ovalid: ack=%b dat=%h expected 0 deadbeef", bus.wbs_ack_o, bus.wbs_dat_o);
    end
  endtask

  task automatic test_abort();
    logic found;
    logic got;
    ctrl_busy = 1'b0;
    bus_drive(1'b0, 32'h3800_0020, 32'h0, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ctrl_in_valid === 1'b1 && ctrl_rw === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found || ctrl_addr !== 23'h20) begin
      n_fail++;
      $display("FAIL abort_issue: read_seen=%b addr=%h expected 1 000020", found, ctrl_addr);
    end
    step();
    bus_idle();
    step();
    ctrl_rdata     = 32'hCAFE_F00D;
    ctrl_out_valid = 1'b1;
    step();
    ctrl_out_valid = 1'b0;
    ctrl_rdata     = 32'h0;
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL abort_noack: ack=%b dat=%h expected 0 deadbeef", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    bus_drive(1'b1, 32'h3800_0030, 32'h0BAD_F00D, 4'h5);
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL abort_next_write: acked=%b expected 1", got);
    end
    bus_idle();
    repeat (5) step();
    n_tests++;
    if (wr_pending !== 1'b0 || log_q[log_q.size()-1].addr !== 23'h30) begin
      n_fail++;
      $display("FAIL abort_drain: pending=%b last_addr=%h expected 0 000030",
               wr_pending, log_q[log_q.size()-1].addr);
    end
  endtask

  task automatic test_decode();
    int   n0;
    logic seen;
    n0 = log_q.size();
    seen = 1'b0;
    bus_drive(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.wbs_ack_o !== 1'b0 || ctrl_in_valid !== 1'b0 || wr_pending !== 1'b0) seen = 1'b1;
    end
    bus_drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.wbs_ack_o !== 1'b0 || ctrl_in_valid !== 1'b0) seen = 1'b1;
    end
    bus_idle();
    n_tests++;
    if (seen || log_q.size() != n0) begin
      n_fail++;
      $display("FAIL decode_miss: activity=%b cmds=%0d expected 0 %0d", seen, log_q.size(), n0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    ctrl_busy = 1'b1;
    bus_drive(1'b1, 32'h3800_0040, 32'h7777_7777, 4'hF);
    step();
    bus_idle();
    step();
    n_tests++;
    if (ctrl_in_valid !== 1'b1 || wr_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: iv=%b pending=%b expected 1 1", ctrl_in_valid, wr_pending);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctrl_in_valid !== 1'b0 || wr_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: iv=%b pending=%b expected 0 0", ctrl_in_valid, wr_pending);
    end
    step();
    rst_n = 1'b1;
    ctrl_busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ctrl_in_valid !== 1'b0 || wr_pending !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_discard: stale write issued after reset, expected none");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_after_write();
    test_abort();
    test_decode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_sdram_bridge.md
# wb_sdram_bridge

- Wishbone-slave front end between the management SoC bus and the `sdram_controller` user port, replacing the combinational glue in the user project wrapper.
- Decodes the memory window and posts writes into a small FIFO so the CPU is acked without waiting on the controller.
- Serialises reads behind pending writes and converts the controller's `in_valid`/`busy`/`out_valid` handshake into a clean one-cycle Wishbone ack.

## Interface
Parameters:
- `ADDR_W`, 23: controller word-address width; `ctrl_addr = wbs_adr_i[ADDR_W-1:0]`.
- `FIFO_DEPTH`, 4: posted-write FIFO entries, power of two, ≥2.
- `BASE`, 8'h38: value of `wbs_adr_i[31:24]` that selects this block.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: single clock.
  - `rst_n` in 1: asynchronous, active-low reset.
- Wishbone slave:
  - `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic strobe, cycle and write enable.
  - `wbs_sel_i` in 4: byte lanes.
  - `wbs_dat_i` in 32: write data.
  - `wbs_adr_i` in 32: byte address.
  - `wbs_ack_o` out 1: registered one-cycle ack.
  - `wbs_dat_o` out 32: read data, valid with ack.
- Controller port:
  - `ctrl_addr` out ADDR_W: command address.
  - `ctrl_rw` out 1: 1 = write.
  - `ctrl_wdata` out 32: write data.
  - `ctrl_mask` out 4: byte mask; 0 for reads.
  - `ctrl_in_valid` out 1: command valid.
  - `ctrl_busy` in 1: controller cannot accept a command.
  - `ctrl_rdata` in 32: read data.
  - `ctrl_out_valid` in 1: read data valid, single-cycle pulse.
- Status:
  - `wr_pending` out 1: FIFO non-empty or write in flight.

## Operation
- `sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24]==BASE)`.
- No request is accepted in a cycle where `wbs_ack_o` is 1; this prevents double-accept while the master drops `stb`.
- Write, `sel & we`, FIFO not full:
  - Push `{addr, dat, sel}`.
  - Ack next cycle.
  - When the FIFO is full: no ack, request held until a slot frees.
  - `wbs_sel_i==0` is still pushed, with an all-off mask.
- Read, `sel & ~we`: accepted only when the FIFO is empty and the FSM is IDLE, so read-after-write ordering is guaranteed by draining the FIFO.
- Issuer FSM:
  - IDLE → WR_ISSUE if the FIFO is non-empty (writes have priority).
  - IDLE → RD_ISSUE if a read is accepted.
  - WR_ISSUE: drive head entry, `ctrl_in_valid=1`, `ctrl_rw=1`. Accepted on a cycle with `in_valid & ~busy`; then pop and go to IDLE.
  - RD_ISSUE: `ctrl_in_valid=1`, `ctrl_rw=0`, `ctrl_mask=0`. On accept → RD_WAIT.
  - RD_WAIT: on `ctrl_out_valid`, capture `ctrl_rdata` into `wbs_dat_o`, pulse ack next cycle, → IDLE.
- Abort: if `wbs_cyc_i` drops while in RD_ISSUE or RD_WAIT, the read still completes at the controller, its data is discarded and no ack is issued.
- Command outputs stay stable while `in_valid & busy`.
- `ctrl_out_valid` outside RD_WAIT is ignored.

## Timing
- Reset values:
  - `wbs_ack_o=0`, `wbs_dat_o=0`.
  - `ctrl_in_valid=0`, `ctrl_rw=0`, `ctrl_addr=0`, `ctrl_wdata=0`, `ctrl_mask=0`.
  - `wr_pending=0`, FIFO empty, FSM IDLE.
- Reset mid-operation discards FIFO contents and any in-flight command; the controller shares `rst_n`.
- Write ack: one cycle after `sel`, if the FIFO is not full.
- A write pushed into an empty FIFO in IDLE is presented to the controller two cycles after `sel`.
- Read ack: cycle of `ctrl_out_valid` + 1.
  - Minimum total: `sel` → in_valid at +1 → accept → out_valid → ack.
- Simultaneous push and pop on a full FIFO: the pop frees the slot the next cycle; a push is never accepted into a full FIFO.

## Structure
- Package `wb_sdram_pkg` holds:
  - `BASE` default.
  - FSM state enum {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT}.
  - FIFO entry struct {addr[ADDR_W], data[32], mask[4]}.
- Sub-module `wb_sdram_wfifo`: synchronous FIFO with full/empty flags, async active-low reset.

## Test plan
- Reset → all outputs 0, `wr_pending=0`, no `ctrl_in_valid` for 10 cycles.
- Write 0x3800_0010 / 0xDEADBEEF / sel F, `ctrl_busy=0` → ack at +1; `in_valid` at +2 with addr 0x000010, rw=1, mask F.
- Five back-to-back writes with `ctrl_busy=1` → four acks. The fifth is acked only after `busy` drops and one pop occurs.
- Write 0xDEADBEEF to 0x3800_0010, then immediately read it → read `in_valid` only after the write is accepted. Controller returns 0xDEADBEEF → ack +1 with `wbs_dat_o=0xDEADBEEF`.
- Read issued, master drops `cyc` before `out_valid` → no ack. A following write is acked normally.
- Access 0x3000_0000 → no ack, no `ctrl_in_valid`, FIFO unchanged.
